// File: rtl/z88_mem_pkg.sv
// Shared definitions for the z88 memory bridges: FSM state encoding, wait counter width
// and a clog2 helper used to size byte-lane selects.
package z88_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   localparam int unsigned WAIT_W = 4;

   // Smallest r with 2**r >= value; returns 0 for value <= 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/z88_lane_mux.sv
// Byte-lane helper shared by the z88 memory bridges: extracts one byte lane from a
// data word and replicates a byte across every lane of a word.
module z88_lane_mux #(
   parameter int unsigned DQ_W   = 16,
   parameter int unsigned LANE_W = 1
) (
   input  logic [DQ_W-1:0]   word,
   input  logic [LANE_W-1:0] lane,
   output logic [7:0]        lane_byte,
   input  logic [7:0]        fill_byte,
   output logic [DQ_W-1:0]   fill_word
);

   localparam int unsigned LANES = DQ_W / 8;

   always_comb begin
      lane_byte = 8'h00;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (lane == LANE_W'(i)) lane_byte = word[8*i +: 8];
      end
   end

   assign fill_word = {LANES{fill_byte}};

endmodule

// File: rtl/z88_sram_bridge.sv
// Byte-request to DQ_W-wide async SRAM bridge with registered CE/OE/WE timing and
// programmable wait states. Optional one-word read buffer: define Z88_SRAM_RDBUF_EN.
module z88_sram_bridge
   import z88_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 19,
   parameter int unsigned DQ_W    = 16,
   parameter int unsigned RD_WAIT = 1,
   parameter int unsigned WR_WAIT = 2
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                req,
   input  logic                                we,
   input  logic [ADDR_W-1:0]                   addr,
   input  logic [7:0]                          wdata,
   output logic [7:0]                          rdata,
   output logic                                ack,
   output logic                                busy,
   output logic [ADDR_W-clog2(DQ_W/8)-1:0]     sram_addr,
   input  logic [DQ_W-1:0]                     sram_dq_i,
   output logic [DQ_W-1:0]                     sram_dq_o,
   output logic                                sram_dq_oe,
   output logic                                sram_ce_n,
   output logic                                sram_oe_n,
   output logic                                sram_we_n,
   output logic [DQ_W/8-1:0]                   sram_be_n
);

   localparam int unsigned LANES     = DQ_W / 8;
   localparam int unsigned LANE_BITS = clog2(LANES);
   localparam int unsigned LANE_W    = (LANE_BITS == 0) ? 1 : LANE_BITS;
   localparam int unsigned WA_W      = ADDR_W - LANE_BITS;

   state_t              state;
   logic [WAIT_W-1:0]   cnt;
   logic                we_q;
   logic [LANE_W-1:0]   lane_q;
   logic [LANE_W-1:0]   req_lane;
   logic [7:0]          rdata_q;
   logic                rd_pass;
   logic [7:0]          rd_byte;
   logic [DQ_W-1:0]     fill_word;
   logic                accept;
   logic                rd_done;
   logic                rd_hit;
   logic [7:0]          hit_byte;

   if (LANE_BITS == 0) begin : g_one_lane
      assign req_lane = '0;
   end else begin : g_lanes
      assign req_lane = addr[LANE_W-1:0];
   end

   z88_lane_mux #(.DQ_W(DQ_W), .LANE_W(LANE_W)) u_lane_mux (
      .word      (sram_dq_i),
      .lane      (lane_q),
      .lane_byte (rd_byte),
      .fill_byte (wdata),
      .fill_word (fill_word)
   );

   // busy also covers the ack cycle of a buffer hit, which is spent in IDLE.
   assign accept  = (state == ST_IDLE) && req && !busy;
   assign rd_done = (state == ST_READ) && (cnt == '0);

   // The sampled byte is passed straight through during the ack cycle so rdata is valid with ack.
   assign rdata = rd_pass ? rd_byte : rdata_q;

`ifdef Z88_SRAM_RDBUF_EN
   logic              buf_valid;
   logic [WA_W-1:0]   buf_tag;
   logic [DQ_W-1:0]   buf_word;
   logic [DQ_W-1:0]   buf_fill;
   logic [DQ_W-1:0]   lane_mask;
   logic              tag_match;

   assign tag_match = buf_valid && (buf_tag == addr[ADDR_W-1:LANE_BITS]);
   assign rd_hit    = tag_match && !we;

   z88_lane_mux #(.DQ_W(DQ_W), .LANE_W(LANE_W)) u_buf_mux (
      .word      (buf_word),
      .lane      (req_lane),
      .lane_byte (hit_byte),
      .fill_byte (wdata),
      .fill_word (buf_fill)
   );

   always_comb begin
      lane_mask = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (req_lane == LANE_W'(i)) lane_mask[8*i +: 8] = 8'hFF;
      end
   end

   // Buffer is filled on a read miss and kept coherent by writes to the same word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_word  <= '0;
      end else if (accept && we && tag_match) begin
         buf_word <= (buf_word & ~lane_mask) | (buf_fill & lane_mask);
      end else if (rd_done) begin
         buf_valid <= 1'b1;
         buf_tag   <= sram_addr;
         buf_word  <= sram_dq_i;
      end
   end
`else
   assign rd_hit   = 1'b0;
   assign hit_byte = 8'h00;
`endif

   // Main FSM; every SRAM-facing output is registered alongside the state it belongs to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         lane_q     <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_be_n  <= '1;
         ack        <= 1'b0;
         busy       <= 1'b0;
         rdata_q    <= 8'h00;
         rd_pass    <= 1'b0;
      end else begin
         ack     <= 1'b0;
         rd_pass <= 1'b0;
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (accept) begin
                  busy <= 1'b1;
                  if (rd_hit) begin
                     ack     <= 1'b1;
                     rdata_q <= hit_byte;
                  end else begin
                     state      <= ST_SETUP;
                     we_q       <= we;
                     lane_q     <= req_lane;
                     sram_addr  <= addr[ADDR_W-1:LANE_BITS];
                     sram_be_n  <= ~(LANES'(1) << req_lane);
                     sram_dq_o  <= fill_word;
                     sram_dq_oe <= we;
                     sram_ce_n  <= 1'b0;
                  end
               end
            end
            ST_SETUP: begin
               if (we_q) begin
                  state      <= ST_WRITE;
                  sram_we_n  <= 1'b0;
                  sram_dq_oe <= 1'b1;
                  cnt        <= WAIT_W'(WR_WAIT);
               end else begin
                  state     <= ST_READ;
                  sram_oe_n <= 1'b0;
                  cnt       <= WAIT_W'(RD_WAIT);
                  ack       <= (RD_WAIT == 0);
                  rd_pass   <= (RD_WAIT == 0);
               end
            end
            ST_READ: begin
               if (cnt == '0) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  rdata_q   <= rd_byte;
                  sram_oe_n <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_be_n <= '1;
               end else begin
                  cnt <= cnt - WAIT_W'(1);
                  if (cnt == WAIT_W'(1)) begin
                     ack     <= 1'b1;
                     rd_pass <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (cnt == '0) begin
                  state     <= ST_HOLD;
                  sram_we_n <= 1'b1;
                  ack       <= 1'b1;
               end else begin
                  cnt <= cnt - WAIT_W'(1);
               end
            end
            ST_HOLD: begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               sram_be_n  <= '1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z88_sram_bridge.sv
// Scoreboard bench for z88_sram_bridge; with Z88_SRAM_RDBUF_EN it runs a 32-bit SRAM
// and adds the read-buffer sequence.
module tb_z88_sram_bridge;

   localparam int unsigned ADDR_W  = 19;
`ifdef Z88_SRAM_RDBUF_EN
   localparam int unsigned DQ_W    = 32;
   localparam bit          RDBUF   = 1'b1;
`else
   localparam int unsigned DQ_W    = 16;
   localparam bit          RDBUF   = 1'b0;
`endif
   localparam int unsigned RD_WAIT = 1;
   localparam int unsigned WR_WAIT = 2;
   localparam int unsigned LANES   = DQ_W / 8;
   localparam int unsigned LB      = $clog2(LANES);

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 req = 1'b0;
   logic                 we = 1'b0;
   logic [ADDR_W-1:0]    addr = '0;
   logic [7:0]           wdata = 8'h00;
   logic [7:0]           rdata;
   logic                 ack;
   logic                 busy;
   logic [ADDR_W-LB-1:0] sram_addr;
   logic [DQ_W-1:0]      sram_dq_i = '0;
   logic [DQ_W-1:0]      sram_dq_o;
   logic                 sram_dq_oe;
   logic                 sram_ce_n;
   logic                 sram_oe_n;
   logic                 sram_we_n;
   logic [LANES-1:0]     sram_be_n;

   z88_sram_bridge #(.ADDR_W(ADDR_W), .DQ_W(DQ_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i),
      .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      int unsigned lat;
      int unsigned oe;
      int unsigned wl;
      int unsigned ce;
      logic [7:0]  rd;
      logic [31:0] sa;
      logic [31:0] be;
      logic [31:0] dqo;
   } exp_t;

   exp_t            sb[$];
   int unsigned     n_checks = 0;
   int unsigned     n_pass = 0;
   logic [7:0]      last_rd = 8'h00;
   bit              mb_valid = 1'b0;
   int unsigned     mb_tag = 0;
   logic [DQ_W-1:0] mb_word = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
   endtask

   // Drive one request, predict its outcome, then watch the bus until ack (or budget).
   task automatic run_op(input string name, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [7:0] d, input logic [DQ_W-1:0] dq, input int unsigned pulse_at);
      exp_t            e, g;
      int unsigned     lane, wa, lat, oe_c, we_c, ce_c, both_c, busy_c;
      logic            got_ack, ack_oe, ack_we_n;
      logic [7:0]      ack_rd;
      logic [31:0]     cap_sa, cap_be, cap_dqo;
      logic [DQ_W-1:0] rep;
      bit              hit;
      lane = a % LANES;
      wa   = a / LANES;
      hit  = RDBUF && !w && mb_valid && (mb_tag == wa);
      rep  = {LANES{d}};
      e.w   = w;
      e.sa  = wa;
      e.be  = ~(32'd1 << lane) & ((32'd1 << LANES) - 32'd1);
      e.dqo = 32'(rep);
      if (hit) begin
         e.lat = 1; e.oe = 0; e.wl = 0; e.ce = 0;
         e.rd  = 8'(mb_word >> (8 * lane));
         last_rd = e.rd;
      end else if (w) begin
         e.lat = 3 + WR_WAIT; e.oe = 0; e.wl = WR_WAIT + 1; e.ce = WR_WAIT + 3;
         e.rd  = last_rd;
         if (RDBUF && mb_valid && (mb_tag == wa)) mb_word[8*lane +: 8] = d;
      end else begin
         e.lat = 2 + RD_WAIT; e.oe = RD_WAIT + 1; e.wl = 0; e.ce = RD_WAIT + 2;
         e.rd  = 8'(dq >> (8 * lane));
         last_rd = e.rd;
         if (RDBUF) begin mb_valid = 1'b1; mb_tag = wa; mb_word = dq; end
      end
      sb.push_back(e);

      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; sram_dq_i = dq;
      lat = 0; oe_c = 0; we_c = 0; ce_c = 0; both_c = 0; busy_c = 0;
      got_ack = 1'b0; ack_oe = 1'b0; ack_we_n = 1'b0; ack_rd = 8'h00;
      cap_sa = '0; cap_be = '0; cap_dqo = '0;
      while (!got_ack && lat < 40) begin
         @(negedge clk);
         lat++;
         req = (lat == pulse_at);
         if (!sram_oe_n) oe_c++;
         if (!sram_we_n) we_c++;
         if (!sram_oe_n && !sram_we_n) both_c++;
         if (busy) busy_c++;
         if (!sram_ce_n) begin
            ce_c++;
            cap_sa = 32'(sram_addr); cap_be = 32'(sram_be_n); cap_dqo = 32'(sram_dq_o);
         end
         if (ack) begin
            got_ack = 1'b1; ack_rd = rdata; ack_oe = sram_dq_oe; ack_we_n = sram_we_n;
         end
      end
      req = 1'b0;

      g = sb.pop_front();
      chk({name, "/ack_seen"}, 32'(got_ack), 32'd1);
      chk({name, "/latency"}, lat, g.lat);
      chk({name, "/rdata"}, 32'(ack_rd), 32'(g.rd));
      chk({name, "/busy_cycles"}, busy_c, g.lat);
      chk({name, "/oe_cycles"}, oe_c, g.oe);
      chk({name, "/we_cycles"}, we_c, g.wl);
      chk({name, "/ce_cycles"}, ce_c, g.ce);
      chk({name, "/oe_we_overlap"}, both_c, 32'd0);
      chk({name, "/ack_dq_oe"}, 32'(ack_oe), 32'(g.w));
      chk({name, "/ack_we_n"}, 32'(ack_we_n), 32'd1);
      if (g.ce != 0) begin
         chk({name, "/sram_addr"}, cap_sa, g.sa);
         chk({name, "/be_n"}, cap_be, g.be);
         chk({name, "/dq_o"}, cap_dqo, g.dqo);
      end
   endtask

   task automatic quiet_window(input string name, input int unsigned cycles);
      int unsigned acks, ces;
      acks = 0; ces = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (ack) acks++;
         if (!sram_ce_n) ces++;
      end
      chk({name, "/extra_ack"}, acks, 32'd0);
      chk({name, "/extra_ce"}, ces, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst/ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst/oe_we_n", {30'd0, sram_oe_n, sram_we_n}, 32'd3);
      chk("rst/be_n", 32'(sram_be_n), (32'd1 << LANES) - 32'd1);
      chk("rst/dq_oe_ack_busy", {29'd0, sram_dq_oe, ack, busy}, 32'd0);
      chk("rst/rdata", 32'(rdata), 32'd0);
      chk("rst/sram_addr", 32'(sram_addr), 32'd0);
      chk("rst/dq_o", 32'(sram_dq_o), 32'd0);
      reset_n = 1'b1;

      run_op("t1_rd_even", 1'b0, 19'h00010, 8'h00, DQ_W'(32'hA55A), 0);
      run_op("t2_rd_odd", 1'b0, 19'h00011, 8'h00, DQ_W'(32'hA55A), 0);
      run_op("t3_wr_top", 1'b1, 19'h7FFFF, 8'h3C, '0, 0);
      run_op("t4_wr_pulse", 1'b1, 19'h00022, 8'h5B, '0, 3);
      quiet_window("t4_after", 8);

      // Reset asserted in the second WRITE cycle must drop strobes immediately.
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 19'h00040; wdata = 8'hC3;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5/pre_we_n", 32'(sram_we_n), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("t5/we_n", 32'(sram_we_n), 32'd1);
      chk("t5/ce_n", 32'(sram_ce_n), 32'd1);
      chk("t5/dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("t5/ack", 32'(ack), 32'd0);
      last_rd = 8'h00;
      mb_valid = 1'b0;
      quiet_window("t5_in_reset", 3);
      reset_n = 1'b1;
      quiet_window("t5_released", 3);
      chk("t5/rdata", 32'(rdata), 32'd0);
      run_op("t5_after_rst", 1'b0, 19'h00040, 8'h00, DQ_W'(32'h1234_5678), 0);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
                8'($urandom), DQ_W'($urandom), 0);
      end

`ifdef Z88_SRAM_RDBUF_EN
      run_op("t6_rd_miss", 1'b0, 19'h00100, 8'h00, DQ_W'(32'h4433_2211), 0);
      run_op("t6_rd_hit", 1'b0, 19'h00102, 8'h00, DQ_W'(32'hDEAD_BEEF), 0);
      run_op("t6_wr", 1'b1, 19'h00103, 8'h77, '0, 0);
      run_op("t6_rd_hit_wr", 1'b0, 19'h00103, 8'h00, '0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
